// File: rtl/calc_pkg.sv
// +-----------------------------------------------------------------------------+
// | calc_pkg : shared types, command codes and 7-segment patterns for calc_core_n |
// | Rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

package calc_pkg;

    typedef enum logic [2:0] {
        S_OP1  = 3'd0,
        S_OP2  = 3'd1,
        S_CALC = 3'd2,
        S_RES  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    localparam logic [3:0] CMD_ADD    = 4'b1010;
    localparam logic [3:0] CMD_SUB    = 4'b1011;
    localparam logic [3:0] CMD_MUL    = 4'b1100;
    localparam logic [3:0] CMD_CLEAR  = 4'b1101;
    localparam logic [3:0] CMD_EQUALS = 4'b1110;
    localparam logic [3:0] CMD_NOP    = 4'b1111;

    localparam logic [1:0] ST_READY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_ERROR = 2'b10;
    localparam logic [1:0] ST_NEG   = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    // gfedcba, active-high
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic op_t op_of(input logic [3:0] c);
        case (c)
            CMD_SUB: return OP_SUB;
            CMD_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_bcd_conv.sv
// +-----------------------------------------------------------------------------+
// | calc_bcd_conv : sequential double-dabble, WIDTH shift cycles per conversion   |
// | Rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module calc_bcd_conv #(
    parameter int WIDTH      = 27,
    parameter int NUM_DIGITS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      start,
    input  logic [WIDTH-1:0]          value,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]        bin;
    logic [4*NUM_DIGITS-1:0] adj;
    logic [CW-1:0]           cnt;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin  <= '0;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (clear) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            bin  <= value;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            {bcd, bin} <= {adj[4*NUM_DIGITS-2:0], bin, 1'b0};
            cnt        <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/calc_core_n.sv
// +-----------------------------------------------------------------------------+
// | calc_core_n : NUM_DIGITS-digit decimal calculator core with 7-segment drive   |
// | Rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module calc_core_n
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cmd_valid,
    input  logic [3:0]                  cmd,
    output logic                        cmd_ready,
    output logic [NUM_DIGITS-1:0][6:0]  displays,
    output logic [1:0]                  status,
    output logic [2:0]                  EA,
    output logic [2:0]                  PE
);

    localparam int WIDTH = $clog2(10**NUM_DIGITS);
    localparam int W2    = 2 * WIDTH;
    localparam int CW    = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] DIG_LIM = WIDTH'(10**(NUM_DIGITS-1));
    localparam logic [W2-1:0]    MAX_POS = W2'(10**NUM_DIGITS - 1);
    localparam logic [W2-1:0]    MAX_NEG = W2'(10**(NUM_DIGITS-1) - 1);
    localparam logic [NUM_DIGITS-1:0][6:0] DISP_RST = {{(NUM_DIGITS-1){SEG_BLANK}}, SEG_ZERO};
    localparam logic [NUM_DIGITS-1:0][6:0] DISP_ERR = {{(NUM_DIGITS-1){SEG_BLANK}}, SEG_E};

    state_t                       state, nxt;
    op_t                          op, op_n;
    logic [WIDTH-1:0]             a, a_n, b, b_n, res_mag, res_mag_n, mplier, mplier_n;
    logic                         b_has, b_has_n, res_neg, res_neg_n, conv_neg, conv_neg_n;
    logic [W2-1:0]                acc, acc_n, mcand, mcand_n, acc_step, calc_mag;
    logic [CW-1:0]                cnt, cnt_n;
    logic [NUM_DIGITS-1:0][6:0]   disp_n, seg_map;
    logic                         calc_neg, calc_done, calc_err;
    logic                         conv_start, conv_busy, conv_done;
    logic [WIDTH-1:0]             conv_val;
    logic [4*NUM_DIGITS-1:0]      conv_bcd;
    logic                         busy, accept, clear_cmd, is_digit, is_op;
    int                           msd;

    calc_bcd_conv #(.WIDTH(WIDTH), .NUM_DIGITS(NUM_DIGITS)) u_conv (
        .clock (clock),
        .reset (reset),
        .clear (clear_cmd),
        .start (conv_start),
        .value (conv_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign busy      = (state == S_CALC) || conv_busy || conv_done;
    assign cmd_ready = !busy;
    assign accept    = cmd_valid && cmd_ready;
    assign clear_cmd = cmd_valid && (cmd == CMD_CLEAR);
    assign is_digit  = (cmd < 4'd10);
    assign is_op     = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);
    assign EA        = state;
    assign PE        = nxt;

    always_comb begin
        if (state == S_ERR)                 status = ST_ERROR;
        else if (busy)                      status = ST_BUSY;
        else if (state == S_RES && res_neg) status = ST_NEG;
        else                                status = ST_READY;
    end

    // Arithmetic unit: one shift-add step per S_CALC cycle for MUL
    always_comb begin
        acc_step = acc + (mplier[0] ? mcand : '0);
        calc_neg = 1'b0;
        case (op)
            OP_SUB: begin
                calc_neg = (b > a);
                calc_mag = calc_neg ? W2'(b - a) : W2'(a - b);
            end
            OP_MUL:  calc_mag = acc_step;
            default: calc_mag = W2'(a) + W2'(b);
        endcase
        calc_done = (op != OP_MUL) || (cnt == CW'(WIDTH - 1));
        calc_err  = (calc_mag > MAX_POS) || (calc_neg && (calc_mag > MAX_NEG));
    end

    // BCD to segments: blank above the most significant digit, minus just above it
    always_comb begin
        msd = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (conv_bcd[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i <= msd)                     seg_map[i] = seg_of(conv_bcd[4*i +: 4]);
            else if (conv_neg && i == msd + 1) seg_map[i] = SEG_MINUS;
            else                              seg_map[i] = SEG_BLANK;
        end
    end

    always_comb begin
        nxt        = state;
        a_n        = a;
        b_n        = b;
        op_n       = op;
        b_has_n    = b_has;
        res_mag_n  = res_mag;
        res_neg_n  = res_neg;
        acc_n      = acc;
        mcand_n    = mcand;
        mplier_n   = mplier;
        cnt_n      = cnt;
        disp_n     = conv_done ? seg_map : displays;
        conv_neg_n = conv_neg;
        conv_start = 1'b0;
        conv_val   = '0;
        case (state)
            S_OP1: if (accept) begin
                if (is_digit) begin
                    if (a < DIG_LIM) begin
                        a_n        = a * WIDTH'(10) + WIDTH'(cmd);
                        conv_start = 1'b1;
                        conv_val   = a_n;
                        conv_neg_n = 1'b0;
                    end
                end else if (is_op) begin
                    op_n    = op_of(cmd);
                    b_n     = '0;
                    b_has_n = 1'b0;
                    nxt     = S_OP2;
                end
            end
            S_OP2: if (accept) begin
                if (is_digit) begin
                    if (b < DIG_LIM) begin
                        b_n        = b * WIDTH'(10) + WIDTH'(cmd);
                        b_has_n    = 1'b1;
                        conv_start = 1'b1;
                        conv_val   = b_n;
                        conv_neg_n = 1'b0;
                    end
                end else if (is_op) begin
                    if (!b_has) op_n = op_of(cmd);
                end else if (cmd == CMD_EQUALS) begin
                    nxt      = S_CALC;
                    acc_n    = '0;
                    mcand_n  = W2'(a);
                    mplier_n = b;
                    cnt_n    = '0;
                end
            end
            S_CALC: begin
                acc_n    = acc_step;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + CW'(1);
                if (calc_done) begin
                    if (calc_err) begin
                        nxt    = S_ERR;
                        disp_n = DISP_ERR;
                    end else begin
                        nxt        = S_RES;
                        res_mag_n  = calc_mag[WIDTH-1:0];
                        res_neg_n  = calc_neg;
                        conv_start = 1'b1;
                        conv_val   = calc_mag[WIDTH-1:0];
                        conv_neg_n = calc_neg;
                    end
                end
            end
            S_RES: if (accept) begin
                if (is_digit) begin
                    a_n        = WIDTH'(cmd);
                    nxt        = S_OP1;
                    conv_start = 1'b1;
                    conv_val   = WIDTH'(cmd);
                    conv_neg_n = 1'b0;
                end else if (is_op) begin
                    if (res_neg) begin
                        nxt    = S_ERR;
                        disp_n = DISP_ERR;
                    end else begin
                        a_n     = res_mag;
                        op_n    = op_of(cmd);
                        b_n     = '0;
                        b_has_n = 1'b0;
                        nxt     = S_OP2;
                    end
                end
            end
            S_ERR:   ;
            default: nxt = S_OP1;
        endcase
        // CLEAR bypasses the handshake and lands on the reset values next cycle
        if (clear_cmd) begin
            nxt        = S_OP1;
            a_n        = '0;
            b_n        = '0;
            op_n       = OP_ADD;
            b_has_n    = 1'b0;
            res_mag_n  = '0;
            res_neg_n  = 1'b0;
            acc_n      = '0;
            mcand_n    = '0;
            mplier_n   = '0;
            cnt_n      = '0;
            disp_n     = DISP_RST;
            conv_neg_n = 1'b0;
            conv_start = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_OP1;
            a        <= '0;
            b        <= '0;
            op       <= OP_ADD;
            b_has    <= 1'b0;
            res_mag  <= '0;
            res_neg  <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            displays <= DISP_RST;
            conv_neg <= 1'b0;
        end else begin
            state    <= nxt;
            a        <= a_n;
            b        <= b_n;
            op       <= op_n;
            b_has    <= b_has_n;
            res_mag  <= res_mag_n;
            res_neg  <= res_neg_n;
            acc      <= acc_n;
            mcand    <= mcand_n;
            mplier   <= mplier_n;
            cnt      <= cnt_n;
            displays <= disp_n;
            conv_neg <= conv_neg_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_calc_core_n.sv
// +-----------------------------------------------------------------------------+
// | tb_calc_core_n : scoreboard bench for calc_core_n (NUM_DIGITS = 8)            |
// | Rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_calc_core_n;

    localparam int NUM_DIGITS = 8;
    localparam int WIDTH      = 27;
    localparam logic [3:0] C_ADD = 4'hA, C_SUB = 4'hB, C_MUL = 4'hC;
    localparam logic [3:0] C_CLR = 4'hD, C_EQ  = 4'hE, C_NOP = 4'hF;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic                        cmd_valid = 1'b0;
    logic [3:0]                  cmd = 4'hF;
    logic                        cmd_ready;
    logic [NUM_DIGITS-1:0][6:0]  displays;
    logic [1:0]                  status;
    logic [2:0]                  EA, PE;

    typedef struct {
        string       tag;
        logic [55:0] disp;
        logic [1:0]  st;
        logic [2:0]  ea;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    calc_core_n #(.NUM_DIGITS(NUM_DIGITS)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .displays  (displays),
        .status    (status),
        .EA        (EA),
        .PE        (PE)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] model_disp(input longint v, input bit neg, input bit err);
        logic [6:0]  tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        logic [55:0] r = '0;
        longint      t = v;
        int          i = 0;
        if (err) begin
            r[6:0] = 7'b1111001;
            return r;
        end
        do begin
            r[i*7 +: 7] = tbl[int'(t % 10)];
            t = t / 10;
            i++;
        end while (t > 0);
        if (neg) r[i*7 +: 7] = 7'b1000000;
        return r;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) check({tag, "_timeout"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic send(input logic [3:0] c);
        wait_ready("send");
        cmd_valid = 1'b1;
        cmd       = c;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd       = C_NOP;
    endtask

    task automatic expect_out(input string tag, input longint v, input bit neg, input bit err,
                              input logic [1:0] st, input logic [2:0] ea);
        exp_t e;
        e.tag  = tag;
        e.disp = model_disp(v, neg, err);
        e.st   = st;
        e.ea   = ea;
        sb.push_back(e);
        wait_ready(tag);
        e = sb.pop_front();
        check({e.tag, "_disp"},   64'(displays), 64'(e.disp));
        check({e.tag, "_status"}, 64'(status),   64'(e.st));
        check({e.tag, "_ea"},     64'(EA),       64'(e.ea));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ea"},    64'(EA),        64'd0);
        check({tag, "_pe"},    64'(PE),        64'd0);
        check({tag, "_stat"},  64'(status),    64'd0);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_disp"},  64'(displays),  64'(model_disp(0, 0, 0)));
    endtask

    initial begin
        int  n;
        bit  saw_calc;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("reset");

        // 12 + 3, then chain + 5
        send(4'd1); send(4'd2); send(C_ADD); send(4'd3); send(C_EQ);
        expect_out("add15", 15, 0, 0, 2'b00, 3'd3);
        send(C_ADD); send(4'd5); send(C_EQ);
        expect_out("chain20", 20, 0, 0, 2'b00, 3'd3);

        // 12 * 3 with busy-window length and state walk
        send(C_CLR); send(4'd1); send(4'd2); send(C_MUL); send(4'd3);
        wait_ready("mul_pre");
        check("mul_ea_op2", 64'(EA), 64'd1);
        send(C_EQ);
        n = 0;
        saw_calc = 0;
        while (!cmd_ready && n < 500) begin
            if (EA == 3'd2) saw_calc = 1;
            @(negedge clock);
            n++;
        end
        check("mul_busy_cycles", 64'(n), 64'(2*WIDTH + 1));
        check("mul_saw_calc", 64'(saw_calc), 64'd1);
        expect_out("mul36", 36, 0, 0, 2'b00, 3'd3);

        // 5 - 9 = -4, then an op on a negative result is an error
        send(C_CLR); send(4'd5); send(C_SUB); send(4'd9); send(C_EQ);
        expect_out("sub_neg4", 4, 1, 0, 2'b11, 3'd3);
        send(C_ADD);
        expect_out("neg_op_err", 0, 0, 1, 2'b10, 3'd4);
        send(C_CLR);
        expect_out("clr_from_err", 0, 0, 0, 2'b00, 3'd0);

        // nine 9s: ninth ignored; +1 overflows
        for (int i = 0; i < 9; i++) send(4'd9);
        expect_out("nine_nines", 99999999, 0, 0, 2'b00, 3'd0);
        send(C_ADD); send(4'd1); send(C_EQ);
        expect_out("overflow", 0, 0, 1, 2'b10, 3'd4);
        send(C_CLR);
        expect_out("clr_ovf", 0, 0, 0, 2'b00, 3'd0);

        // op replaced before any B digit
        send(4'd6); send(C_ADD); send(C_SUB); send(4'd2); send(C_EQ);
        expect_out("op_replace", 4, 0, 0, 2'b00, 3'd3);

        // negative limits: -9999999 fits, -10000000 does not
        send(C_CLR); send(C_SUB);
        for (int i = 0; i < 7; i++) send(4'd9);
        send(C_EQ);
        expect_out("neg_max", 9999999, 1, 0, 2'b11, 3'd3);
        send(C_CLR); send(C_SUB); send(4'd1);
        for (int i = 0; i < 7; i++) send(4'd0);
        send(C_EQ);
        expect_out("neg_ovf", 0, 0, 1, 2'b10, 3'd4);

        // digit offered while converting is dropped
        send(C_CLR); send(4'd4);
        cmd_valid = 1'b1; cmd = 4'd5;
        @(negedge clock);
        cmd_valid = 1'b0; cmd = C_NOP;
        expect_out("drop_busy", 4, 0, 0, 2'b00, 3'd0);

        // CLEAR aborts a long multiply
        send(C_CLR);
        for (int i = 0; i < 4; i++) send(4'd9);
        send(C_MUL);
        for (int i = 0; i < 4; i++) send(4'd9);
        send(C_EQ);
        repeat (5) @(negedge clock);
        check("abort_in_calc", 64'(EA), 64'd2);
        check("abort_busy_stat", 64'(status), 64'd1);
        cmd_valid = 1'b1; cmd = C_CLR;
        #1 check("abort_pe", 64'(PE), 64'd0);
        @(negedge clock);
        cmd_valid = 1'b0; cmd = C_NOP;
        check_reset_vals("abort");

        // asynchronous reset during a conversion
        send(4'd1); send(4'd2);
        check("pre_reset_busy", 64'(cmd_ready), 64'd0);
        #3 reset = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send(4'd3);
        expect_out("after_rst", 3, 0, 0, 2'b00, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
